// File: rtl/hex_display_mux.sv
// Two-digit multiplexed 7-segment driver: shows hex_val as two hex digits, alternating digits every CLK_FREQ/REFRESH_HZ cycles.
// Optional macro HEX_LEADING_ZERO_BLANK_EN darkens the left digit when the high nibble is zero.
module hex_display_mux #(
    parameter int CLK_FREQ   = 12_000_000,
    parameter int REFRESH_HZ = 1_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] hex_val,
    output logic       digit_sel,
    output logic [6:0] seg_pins
);

    localparam int DIV = CLK_FREQ / REFRESH_HZ;
    localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);

    if (DIV < 2) begin : g_div_check
        $error("hex_display_mux: CLK_FREQ/REFRESH_HZ must be >= 2");
    end

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sel_q, sel_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    nibble;
    logic          tick;

    assign tick = (cnt_q == CW'(DIV - 1));

    // NOTE: every variable gets a default first so no path through this block can infer a latch.
    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        sel_d  = sel_q;
        seg_d  = seg_q;
        nibble = 4'h0;
        if (tick) begin
            cnt_d  = '0;
            sel_d  = ~sel_q;
            // Select by the new digit_sel so the pin pair always matches.
            nibble = sel_d ? hex_val[7:4] : hex_val[3:0];
            seg_d  = decode(nibble);
`ifdef HEX_LEADING_ZERO_BLANK_EN
            if (sel_d && (hex_val[7:4] == 4'h0)) begin
                seg_d = 7'h00;
            end
`endif
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sel_q <= 1'b0;
            seg_q <= 7'h00;
        end else begin
            cnt_q <= cnt_d;
            sel_q <= sel_d;
            seg_q <= seg_d;
        end
    end

    assign digit_sel = sel_q;
    assign seg_pins  = seg_q;

endmodule

// File: tb/tb_hex_display_mux.sv
// Directed self-checking bench for hex_display_mux with DIV = 40/10 = 4.
module tb_hex_display_mux;

    logic       clk;
    logic       clk_en;
    logic       rst_n;
    logic [7:0] hex_val;
    logic       digit_sel;
    logic [6:0] seg_pins;

    int checks = 0;
    int errors = 0;

    hex_display_mux #(.CLK_FREQ(40), .REFRESH_HZ(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hex_val   (hex_val),
        .digit_sel (digit_sel),
        .seg_pins  (seg_pins)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // Segment patterns as listed in the gfedcba table.
    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] tbl [16];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return tbl[n];
    endfunction

    function automatic logic [6:0] left_of(input logic [3:0] n);
`ifdef HEX_LEADING_ZERO_BLANK_EN
        if (n == 4'h0) return 7'h00;
`endif
        return seg_of(n);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic [7:0] v);
        @(negedge clk);
        hex_val = v;
        rst_n   = 1'b0;
        #2;
        rst_n   = 1'b1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b1;
        #3;
        rst_n  = 1'b0;
        #1;
        checks++;
        if (digit_sel !== 1'b0) begin
            errors++;
            $display("FAIL reset_sel got %b expected 0", digit_sel);
        end
        checks++;
        if (seg_pins !== 7'h00) begin
            errors++;
            $display("FAIL reset_seg got %h expected 00", seg_pins);
        end
        clk_en = 1'b1;
        repeat (2) @(posedge clk);
        apply_reset(8'h00);
        for (int e = 1; e <= 4; e++) begin
            step();
            checks++;
            if (digit_sel !== (e == 4)) begin
                errors++;
                $display("FAIL release_sel edge %0d got %b expected %b", e, digit_sel, (e == 4));
            end
            checks++;
            if (seg_pins !== ((e == 4) ? left_of(4'h0) : 7'h00)) begin
                errors++;
                $display("FAIL release_seg edge %0d got %h expected %h", e, seg_pins,
                         (e == 4) ? left_of(4'h0) : 7'h00);
            end
        end
    endtask

    task automatic test_multiplex();
        logic       es;
        logic [6:0] eg;
        apply_reset(8'hA5);
        for (int e = 1; e <= 16; e++) begin
            step();
            es = (e >= 4) ? ((e / 4) % 2 == 1) : 1'b0;
            eg = (e < 4) ? 7'h00 : (es ? 7'h77 : 7'h6D);
            checks++;
            if (digit_sel !== es || seg_pins !== eg) begin
                errors++;
                $display("FAIL mux edge %0d got sel=%b seg=%h expected sel=%b seg=%h",
                         e, digit_sel, seg_pins, es, eg);
            end
        end
    endtask

    task automatic test_decode_sweep();
        logic [7:0] vals [8];
        vals = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        apply_reset(vals[0]);
        for (int i = 0; i < 8; i++) begin
            hex_val = vals[i];
            repeat (4) step();
            checks++;
            if (digit_sel !== 1'b1 || seg_pins !== left_of(vals[i][7:4])) begin
                errors++;
                $display("FAIL sweep_left %h got sel=%b seg=%h expected sel=1 seg=%h",
                         vals[i], digit_sel, seg_pins, left_of(vals[i][7:4]));
            end
            repeat (4) step();
            checks++;
            if (digit_sel !== 1'b0 || seg_pins !== seg_of(vals[i][3:0])) begin
                errors++;
                $display("FAIL sweep_right %h got sel=%b seg=%h expected sel=0 seg=%h",
                         vals[i], digit_sel, seg_pins, seg_of(vals[i][3:0]));
            end
        end
    endtask

    task automatic test_late_change();
        logic       es;
        logic [6:0] eg;
        apply_reset(8'h12);
        repeat (4) step();
        for (int e = 5; e <= 12; e++) begin
            step();
            if (e == 5) hex_val = 8'h3C;
            es = (e < 8 || e == 12);
            eg = (e < 8) ? 7'h06 : ((e == 12) ? 7'h4F : 7'h39);
            checks++;
            if (digit_sel !== es || seg_pins !== eg) begin
                errors++;
                $display("FAIL late edge %0d got sel=%b seg=%h expected sel=%b seg=%h",
                         e, digit_sel, seg_pins, es, eg);
            end
        end
    endtask

    task automatic test_mid_reset();
        apply_reset(8'hA5);
        repeat (6) step();
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (digit_sel !== 1'b0 || seg_pins !== 7'h00) begin
            errors++;
            $display("FAIL midreset_immediate got sel=%b seg=%h expected sel=0 seg=00",
                     digit_sel, seg_pins);
        end
        #3;
        rst_n = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            step();
            checks++;
            if (digit_sel !== (e == 4) || seg_pins !== ((e == 4) ? 7'h77 : 7'h00)) begin
                errors++;
                $display("FAIL midreset_edge %0d got sel=%b seg=%h expected sel=%b seg=%h",
                         e, digit_sel, seg_pins, (e == 4), (e == 4) ? 7'h77 : 7'h00);
            end
        end
    endtask

    task automatic test_leading_zero();
        logic [6:0] exp_left;
`ifdef HEX_LEADING_ZERO_BLANK_EN
        exp_left = 7'h00;
`else
        exp_left = 7'h3F;
`endif
        apply_reset(8'h07);
        repeat (4) step();
        checks++;
        if (digit_sel !== 1'b1 || seg_pins !== exp_left) begin
            errors++;
            $display("FAIL lz_left got sel=%b seg=%h expected sel=1 seg=%h",
                     digit_sel, seg_pins, exp_left);
        end
        repeat (4) step();
        checks++;
        if (digit_sel !== 1'b0 || seg_pins !== 7'h07) begin
            errors++;
            $display("FAIL lz_right got sel=%b seg=%h expected sel=0 seg=07", digit_sel, seg_pins);
        end
        hex_val = 8'h00;
        repeat (8) step();
        checks++;
        if (digit_sel !== 1'b0 || seg_pins !== 7'h3F) begin
            errors++;
            $display("FAIL lz_right_zero got sel=%b seg=%h expected sel=0 seg=3F", digit_sel, seg_pins);
        end
    endtask

    initial begin
        clk_en  = 1'b0;
        rst_n   = 1'b1;
        hex_val = 8'h00;
        test_reset();
        test_multiplex();
        test_decode_sweep();
        test_late_change();
        test_mid_reset();
        test_leading_zero();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
